// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port register file, two write ports with bypass and a
//              per-register pending-write scoreboard.     Rev 1.0
// ============================================================================
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          waddr0,
   input  logic [DATA_W-1:0]          wdata0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          waddr1,
   input  logic [DATA_W-1:0]          wdata1,
   input  logic                       alloc_en,
   input  logic [ADDR_W-1:0]          alloc_addr,
   input  logic [NUM_RD-1:0]          re,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic [NUM_RD-1:0]          rbusy,
   output logic [ADDR_W:0]            busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   busy_cnt_q;
   logic [ADDR_W:0]   busy_cnt_d;

   // Port 1 is applied after port 0 so it wins on an address collision;
   // alloc is applied last so a new producer overrides a retiring one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (we0) begin
         regs_d[waddr0] = wdata0;
         busy_d[waddr0] = 1'b0;
      end
      if (we1) begin
         regs_d[waddr1] = wdata1;
         busy_d[waddr1] = 1'b0;
      end
      if (alloc_en) begin
         busy_d[alloc_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         regs_d[0] = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;
      logic              rd_busy;
      logic              hit0;
      logic              hit1;

      assign ra = raddr[k*ADDR_W +: ADDR_W];

      // Outputs are forced to zero while in reset, including the bypass path.
      always_comb begin
         hit0    = we0 && (waddr0 == ra);
         hit1    = we1 && (waddr1 == ra);
         rd_val  = '0;
         rd_busy = 1'b0;
         if (rst && re[k] && !((ZERO_REG != 0) && (ra == '0))) begin
            if (hit1) begin
               rd_val = wdata1;
            end else if (hit0) begin
               rd_val = wdata0;
            end else begin
               rd_val = regs_q[ra];
            end
            rd_busy = busy_q[ra] && !hit0 && !hit1;
         end
      end

      assign rdata[k*DATA_W +: DATA_W] = rd_val;
      assign rbusy[k]                  = rd_busy;
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp : directed scoreboard bench for regfile_mp.     Rev 1.0
// ============================================================================
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   typedef struct {
      int          port;
      logic [31:0] data;
      logic        busy;
   } rd_exp_t;

   logic              clk;
   logic              rst;
   logic              we0;
   logic [AW-1:0]     waddr0;
   logic [DW-1:0]     wdata0;
   logic              we1;
   logic [AW-1:0]     waddr1;
   logic [DW-1:0]     wdata1;
   logic              alloc_en;
   logic [AW-1:0]     alloc_addr;
   logic [NR-1:0]     re;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic [NR-1:0]     rbusy;
   logic [AW:0]       busy_cnt;

   logic              cnt_chk;
   rd_exp_t           rq[$];
   logic [AW:0]       cq[$];
   int                n_chk;
   int                n_fail;

   regfile_mp #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NR),
      .ZERO_REG (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .we0        (we0),
      .waddr0     (waddr0),
      .wdata0     (wdata0),
      .we1        (we1),
      .waddr1     (waddr1),
      .wdata1     (wdata1),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .re         (re),
      .raddr      (raddr),
      .rdata      (rdata),
      .rbusy      (rbusy),
      .busy_cnt   (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every enabled read port and every flagged count is compared on
   // the falling edge against the next queued expectation.
   always @(negedge clk) begin
      rd_exp_t e;
      for (int k = 0; k < NR; k++) begin
         if (re[k]) begin
            n_chk = n_chk + 1;
            if (rq.size() == 0) begin
               n_fail = n_fail + 1;
               $display("FAIL read_unexpected port %0d: no expectation queued", k);
            end else begin
               e = rq.pop_front();
               if (e.port != k || rdata[k*DW +: DW] != e.data || rbusy[k] !== e.busy) begin
                  n_fail = n_fail + 1;
                  $display("FAIL read port %0d t=%0t: got data %h busy %b, expected port %0d data %h busy %b",
                           k, $time, rdata[k*DW +: DW], rbusy[k], e.port, e.data, e.busy);
               end
            end
         end
      end
      if (cnt_chk) begin
         n_chk = n_chk + 1;
         if (cq.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL busy_cnt_unexpected: no expectation queued");
         end else begin
            logic [AW:0] ec;
            ec = cq.pop_front();
            if (busy_cnt !== ec) begin
               n_fail = n_fail + 1;
               $display("FAIL busy_cnt t=%0t: got %0d, expected %0d", $time, busy_cnt, ec);
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
      we0      = 1'b0;
      we1      = 1'b0;
      alloc_en = 1'b0;
      re       = '0;
      cnt_chk  = 1'b0;
   endtask

   // Reads must be issued in ascending port order within a cycle.
   task automatic rd(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic b);
      rd_exp_t e;
      re[p]            = 1'b1;
      raddr[p*AW +: AW] = a;
      e.port = p;
      e.data = d;
      e.busy = b;
      rq.push_back(e);
   endtask

   task automatic cnt(input int c);
      cnt_chk = 1'b1;
      cq.push_back(c[AW:0]);
   endtask

   task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d);
      we0 = 1'b1; waddr0 = a; wdata0 = d;
   endtask

   task automatic wr1(input logic [AW-1:0] a, input logic [31:0] d);
      we1 = 1'b1; waddr1 = a; wdata1 = d;
   endtask

   task automatic alloc(input logic [AW-1:0] a);
      alloc_en = 1'b1; alloc_addr = a;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b0; cnt_chk = 1'b0;
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      alloc_en = 1'b0; alloc_addr = '0;
      re = '0; raddr = '0;

      // In reset: bypass must not leak to rdata
      next(); wr1(5'd2, 32'hDEAD_BEEF); rd(0, 5'd2, 32'h0, 1'b0); cnt(0);
      next(); rst = 1'b1;

      // Reset values and zero register
      next(); rd(0, 5'd0, 32'h0, 1'b0); rd(1, 5'd7, 32'h0, 1'b0); cnt(0);
      next(); wr0(5'd0, 32'hFFFF_FFFF); rd(0, 5'd0, 32'h0, 1'b0);
      next(); rd(0, 5'd0, 32'h0, 1'b0);

      // Write, same-cycle bypass, then registered read
      next(); wr0(5'd5, 32'h1234_5678); rd(1, 5'd5, 32'h1234_5678, 1'b0);
      next(); rd(0, 5'd5, 32'h1234_5678, 1'b0); rd(1, 5'd5, 32'h1234_5678, 1'b0);

      // Write-port priority
      next(); wr0(5'd9, 32'hAAAA_AAAA); wr1(5'd9, 32'h5555_5555); rd(0, 5'd9, 32'h5555_5555, 1'b0);
      next(); rd(0, 5'd9, 32'h5555_5555, 1'b0); rd(1, 5'd9, 32'h5555_5555, 1'b0);

      // Scoreboard set/clear on r3
      next(); alloc(5'd3); rd(0, 5'd3, 32'h0, 1'b0); cnt(0);
      next(); rd(0, 5'd3, 32'h0, 1'b1); cnt(1);
      next(); wr1(5'd3, 32'h0000_00C3); rd(0, 5'd3, 32'h0000_00C3, 1'b0); cnt(1);
      next(); rd(0, 5'd3, 32'h0000_00C3, 1'b0); cnt(0);

      // Alloc and write on busy r4 in the same cycle: alloc wins
      next(); alloc(5'd4); cnt(0);
      next(); alloc(5'd4); wr0(5'd4, 32'h0000_0044); rd(0, 5'd4, 32'h0000_0044, 1'b0); cnt(1);
      next(); rd(0, 5'd4, 32'h0000_0044, 1'b1); cnt(1);
      next(); alloc(5'd0); cnt(1);
      next(); alloc(5'd4); rd(0, 5'd0, 32'h0, 1'b0); cnt(1);
      next(); cnt(1);
      next(); wr1(5'd4, 32'h0000_0045); rd(1, 5'd4, 32'h0000_0045, 1'b0);
      next(); cnt(0); rd(0, 5'd4, 32'h0000_0045, 1'b0);

      // Fill r1..r10 busy, then reset mid-cycle
      next(); wr0(5'd1, 32'h0000_0011);
      for (int i = 1; i <= 10; i++) begin
         next(); alloc(i[AW-1:0]); cnt(i - 1);
      end
      next(); cnt(10); rd(0, 5'd1, 32'h0000_0011, 1'b1); rd(1, 5'd10, 32'h0, 1'b1);
      next(); rst = 1'b0; wr1(5'd2, 32'h0000_0077); alloc(5'd12);
      rd(0, 5'd1, 32'h0, 1'b0); rd(1, 5'd2, 32'h0, 1'b0); cnt(0);
      next(); rst = 1'b1;
      next(); rd(0, 5'd1, 32'h0, 1'b0); rd(1, 5'd10, 32'h0, 1'b0); cnt(0);
      next(); rd(0, 5'd12, 32'h0, 1'b0); rd(1, 5'd2, 32'h0, 1'b0);
      next();

      n_chk = n_chk + 1;
      if (rq.size() != 0 || cq.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL queues_drained: %0d read and %0d count expectations left, expected 0 and 0",
                  rq.size(), cq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
